// File: rtl/vpm_hz_pkg.sv
// vpm_hz_pkg: shared types and widths for the vpm hazard controller.
package vpm_hz_pkg;

  // Input-gating state of the controller.
  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_FLUSH_WAIT,
    HZ_DRAIN
  } hz_state_t;

  // Widths of the optional performance counters.
  localparam int HZ_PERF_CYC_W   = 32;
  localparam int HZ_PERF_FLUSH_W = 16;

endpackage

// File: rtl/vpm_hz_valid_stage.sv
// vpm_hz_valid_stage: one pipeline stage's valid bit, register enable and
// source selection for the vpm hazard controller.
module vpm_hz_valid_stage (
  input  logic clk,
  input  logic rst,
  input  logic hold,      // this stage must keep its contents
  input  logic kill,      // this stage is flushed this cycle
  input  logic up_valid,  // upstream valid (stage 0: accepted input)
  input  logic up_hold,   // upstream is holding its item
  input  logic up_kill,   // upstream is being flushed
  output logic en,
  output logic valid
);

  logic src;

  // A flushed stage is always written so its register clears even if stalled.
  assign en  = ~hold | kill;
  // The upstream item moves in only if it is neither held nor being killed.
  assign src = up_valid & ~up_hold & ~up_kill;

  // Valid bit: kill clears, enable loads the upstream item, otherwise keep.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments in clocked blocks, so every register samples pre-edge values.
    if (rst)       valid <= 1'b0;
    else if (kill) valid <= 1'b0;
    else if (en)   valid <= src;
  end

endmodule

// File: rtl/vpm_hazard_ctrl.sv
// vpm_hazard_ctrl: per-stage clock enables and active-low flush strobes for an
// N-stage linear vpm pipeline, with backpressure, bubble squash, post-flush
// redirect hold and whole-pipe drain.
// Optional macro VPM_HZ_PERF_EN adds saturating stall-cycle and flush counters.
module vpm_hazard_ctrl
  import vpm_hz_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int FLUSH_HOLD = 2,
  parameter int STAGE_W    = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic                  o_ready,
  output logic                  o_valid,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  flush_req,
  input  logic [STAGE_W-1:0]    flush_stage,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic [NUM_STAGES-1:0] hz_en,
  output logic [NUM_STAGES-1:0] hz_flush_n,
  output logic [NUM_STAGES-1:0] stage_valid
`ifdef VPM_HZ_PERF_EN
  ,
  output logic [HZ_PERF_CYC_W-1:0]   perf_stall_cyc,
  output logic [HZ_PERF_FLUSH_W-1:0] perf_flush_cnt
`endif
);

  localparam int LAST  = NUM_STAGES - 1;
  localparam int CNT_W = (FLUSH_HOLD > 1) ? $clog2(FLUSH_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'((FLUSH_HOLD > 0) ? FLUSH_HOLD - 1 : 0);

  hz_state_t             state;
  logic [CNT_W-1:0]      hold_cnt;
  logic [NUM_STAGES-1:0] valid;
  logic [NUM_STAGES-1:0] hold;
  logic [NUM_STAGES-1:0] kill;
  logic                  accept;
  int                    flush_lim;

  // Oldest stage killed; out-of-range requests clamp to the output stage.
  always_comb begin
    flush_lim = int'(flush_stage);
    if (flush_lim > LAST) flush_lim = LAST;
  end

  // Kill mask covers stages 0..flush_lim while flush_req is high.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    kill = '0;
    for (int k = 0; k < NUM_STAGES; k++) kill[k] = flush_req & (k <= flush_lim);
  end

  // Hold chain, oldest first; an empty stage never passes hold upstream.
  always_comb begin
    hold       = '0;
    hold[LAST] = stall_req[LAST] | (valid[LAST] & ~o_ready);
    for (int k = LAST - 1; k >= 0; k--) hold[k] = stall_req[k] | (valid[k] & hold[k+1]);
  end

  assign i_ready     = ~hold[0] & (state == HZ_RUN) & ~kill[0] & ~drain_req;
  assign accept      = i_valid & i_ready;
  assign o_valid     = valid[LAST];
  assign hz_flush_n  = ~kill;
  assign stage_valid = valid;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      vpm_hz_valid_stage u_stage (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold[k]),
        .kill     (kill[k]),
        .up_valid (accept),
        .up_hold  (1'b0),
        .up_kill  (1'b0),
        .en       (hz_en[k]),
        .valid    (valid[k])
      );
    end else begin : g_body
      vpm_hz_valid_stage u_stage (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold[k]),
        .kill     (kill[k]),
        .up_valid (valid[k-1]),
        .up_hold  (hold[k-1]),
        .up_kill  (kill[k-1]),
        .en       (hz_en[k]),
        .valid    (valid[k])
      );
    end
  end

  // Input gating FSM: redirect hold after flush, drain until empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HZ_RUN;
      hold_cnt   <= '0;
      drain_done <= 1'b0;
    end else begin
      drain_done <= 1'b0;
      unique case (state)
        HZ_RUN: begin
          if (flush_req && (FLUSH_HOLD > 0)) begin
            state    <= HZ_FLUSH_WAIT;
            hold_cnt <= HOLD_RELOAD;
          end else if (drain_req) begin
            state <= HZ_DRAIN;
          end
        end
        HZ_FLUSH_WAIT: begin
          if (flush_req)            hold_cnt <= HOLD_RELOAD;
          else if (hold_cnt == '0)  state    <= HZ_RUN;
          else                      hold_cnt <= hold_cnt - CNT_W'(1);
        end
        HZ_DRAIN: begin
          // A flush during drain only kills; completion waits for a quiet cycle.
          if (!flush_req && (valid == '0) && !accept) begin
            state      <= HZ_RUN;
            drain_done <= 1'b1;
          end
        end
        default: state <= HZ_RUN;
      endcase
    end
  end

`ifdef VPM_HZ_PERF_EN
  // Saturating counters of blocked-input cycles and flush requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (i_valid && !i_ready && (perf_stall_cyc != '1))
        perf_stall_cyc <= perf_stall_cyc + HZ_PERF_CYC_W'(1);
      if (flush_req && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + HZ_PERF_FLUSH_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vpm_hazard_ctrl.sv
// tb_vpm_hazard_ctrl: directed and randomized bench for vpm_hazard_ctrl with a
// slot-occupancy reference model and a queue-based scoreboard.
module tb_vpm_hazard_ctrl;

  localparam int N  = 5;
  localparam int FH = 2;
  localparam int SW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_ready, o_ready, o_valid;
  logic [N-1:0]  stall_req, hz_en, hz_flush_n, stage_valid;
  logic          flush_req, drain_req, drain_done;
  logic [SW-1:0] flush_stage;
`ifdef VPM_HZ_PERF_EN
  logic [31:0]   perf_stall_cyc;
  logic [15:0]   perf_flush_cnt;
`endif

  vpm_hazard_ctrl #(.NUM_STAGES(N), .FLUSH_HOLD(FH)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .flush_stage (flush_stage),
    .drain_req   (drain_req),
    .drain_done  (drain_done),
    .hz_en       (hz_en),
    .hz_flush_n  (hz_flush_n),
    .stage_valid (stage_valid)
`ifdef VPM_HZ_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         i_ready;
    logic         o_valid;
    logic         drain_done;
    logic [N-1:0] hz_en;
    logic [N-1:0] hz_flush_n;
    logic [N-1:0] stage_valid;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: slot occupancy plus input-blocking bookkeeping.
  bit occ[N];
  int block_left;   // cycles of redirect hold still to come
  bit draining;
  bit m_done;       // drain_done value the DUT presents this cycle

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) occ[k] = 1'b0;
    block_left = 0;
    draining   = 1'b0;
    m_done     = 1'b0;
  endtask

  // Evaluate this cycle's outputs from current inputs, then advance the model.
  task automatic model_step(output exp_t e);
    bit stuck[N];
    bit killed[N];
    bit nxt[N];
    bit downstream_stuck, acc, busy, empty;
    int fs;
    fs = (int'(flush_stage) >= N) ? N - 1 : int'(flush_stage);
    for (int k = 0; k < N; k++) killed[k] = flush_req && (k <= fs);
    for (int k = N - 1; k >= 0; k--) begin
      downstream_stuck = (k == N - 1) ? !o_ready : stuck[k+1];
      stuck[k] = stall_req[k] || (occ[k] && downstream_stuck);
    end
    busy = (block_left > 0) || draining;
    e.i_ready    = !stuck[0] && !busy && !killed[0] && !drain_req;
    e.o_valid    = occ[N-1];
    e.drain_done = m_done;
    acc   = i_valid && e.i_ready;
    empty = 1'b1;
    for (int k = 0; k < N; k++) begin
      e.hz_en[k]       = !stuck[k] || killed[k];
      e.hz_flush_n[k]  = !killed[k];
      e.stage_valid[k] = occ[k];
      if (occ[k]) empty = 1'b0;
      if (killed[k])     nxt[k] = 1'b0;
      else if (stuck[k]) nxt[k] = occ[k];
      else if (k == 0)   nxt[k] = acc;
      else               nxt[k] = occ[k-1] && !stuck[k-1] && !killed[k-1];
    end
    m_done = 1'b0;
    if (draining) begin
      if (!flush_req && empty && !acc) begin
        draining = 1'b0;
        m_done   = 1'b1;
      end
    end else if (block_left > 0) begin
      block_left = flush_req ? FH : block_left - 1;
    end else if (flush_req && FH > 0) begin
      block_left = FH;
    end else if (drain_req) begin
      draining = 1'b1;
    end
    occ = nxt;
  endtask

  // Drive one cycle of inputs and queue the expected response.
  task automatic step(input logic iv, input logic ordy, input logic [N-1:0] st,
                      input logic fl, input logic [SW-1:0] fs, input logic dr);
    exp_t e;
    @(posedge clk);
    #2;
    i_valid = iv; o_ready = ordy; stall_req = st;
    flush_req = fl; flush_stage = fs; drain_req = dr;
    model_step(e);
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the queued expectation on every falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_i_ready",     i_ready,     e.i_ready);
        check("sb_o_valid",     o_valid,     e.o_valid);
        check("sb_drain_done",  drain_done,  e.drain_done);
        check("sb_hz_en",       hz_en,       e.hz_en);
        check("sb_hz_flush_n",  hz_flush_n,  e.hz_flush_n);
        check("sb_stage_valid", stage_valid, e.stage_valid);
      end
    end
  end

  initial begin
    logic [N-1:0] bub_valid [3];
    logic         post_flush_rdy [3];
    bit           done_seen;
    int           guard;
    int           dr_left;

    bub_valid      = '{5'b10101, 5'b11010, 5'b11100};
    post_flush_rdy = '{1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    i_valid = 1'b0; o_ready = 1'b0; stall_req = '0;
    flush_req = 1'b0; flush_stage = '0; drain_req = 1'b0;
    model_reset();
    #3;
    check("rst_i_ready",     i_ready,     1);
    check("rst_o_valid",     o_valid,     0);
    check("rst_hz_en",       hz_en,       5'b11111);
    check("rst_hz_flush_n",  hz_flush_n,  5'b11111);
    check("rst_stage_valid", stage_valid, 0);
    check("rst_drain_done",  drain_done,  0);
    #9 rst = 1'b0;

    // Fill: output valid appears five cycles after the first accept.
    for (int i = 0; i < 8; i++) begin
      step(1, 1, '0, 0, '0, 0); #2;
      check("fill_o_valid", o_valid, (i >= 5) ? 1 : 0);
      check("fill_hz_en",   hz_en,   5'b11111);
    end

    // Backpressure on a full pipe freezes everything.
    for (int i = 0; i < 3; i++) begin
      step(1, 0, '0, 0, '0, 0); #2;
      check("bp_hz_en",       hz_en,       0);
      check("bp_i_ready",     i_ready,     0);
      check("bp_stage_valid", stage_valid, 5'b11111);
    end

    // Empty, then build 10101 and squash bubbles under backpressure.
    for (int i = 0; i < 6; i++) step(0, 1, '0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(((i % 2) == 0) ? 1'b1 : 1'b0, 1, '0, 0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 0, '0, 0); #2;
      check("bub_stage_valid", stage_valid, bub_valid[i]);
      check("bub_hz_en_lo",    hz_en[1:0],  2'b11);
    end

    // Flush stages 0..2 of a full pipe while the output is blocked.
    for (int i = 0; i < 6; i++) step(1, 1, '0, 0, '0, 0);
    step(1, 0, '0, 1, 3'd2, 0); #2;
    check("fl_hz_flush_n", hz_flush_n, 5'b11000);
    check("fl_i_ready",    i_ready,    0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, '0, 0, '0, 0); #2;
      check("fl_hold_i_ready", i_ready, post_flush_rdy[i]);
      if (i == 0) check("fl_stage_valid", stage_valid, 5'b11000);
    end

    // Flush beats a stall on a killed stage; stage 3 still advances.
    for (int i = 0; i < 6; i++) step(1, 1, '0, 0, '0, 0);
    step(0, 1, 5'b00010, 1, 3'd2, 0); #2;
    check("fs_hz_en", hz_en, 5'b11111);
    step(0, 1, '0, 0, '0, 0); #2;
    check("fs_stage_valid", stage_valid, 5'b10000);
    for (int i = 0; i < 6; i++) step(0, 1, '0, 0, '0, 0);

    // Drain with three items in flight.
    for (int i = 0; i < 3; i++) step(1, 1, '0, 0, '0, 0);
    done_seen = 1'b0;
    guard     = 0;
    while (!done_seen && guard < 20) begin
      if (m_done) begin
        step(1, 1, '0, 0, '0, 0); #2;
        check("dr_done_pulse",  drain_done,  1);
        check("dr_empty",       stage_valid, 0);
        check("dr_ready_after", i_ready,     1);
        done_seen = 1'b1;
      end else begin
        step(1, 1, '0, 0, '0, 1); #2;
        check("dr_blocks_input", i_ready, 0);
      end
      guard++;
    end
    check("dr_completed", done_seen, 1);
    step(0, 1, '0, 0, '0, 0); #2;
    check("dr_single_pulse", drain_done, 0);
    check("dr_new_item",     stage_valid, 5'b00001);

    // Randomized traffic, including clamped flush_stage values and drain windows.
    dr_left = 0;
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] st;
      for (int k = 0; k < N; k++) st[k] = ($urandom_range(0, 9) == 0);
      if (dr_left == 0 && $urandom_range(0, 39) == 0) dr_left = $urandom_range(3, 15);
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), st,
           ($urandom_range(0, 11) == 0), SW'($urandom_range(0, 7)), dr_left > 0);
      if (dr_left > 0) dr_left--;
    end

    // Reset in the middle of the redirect hold.
    step(0, 1, '0, 0, '0, 0);
    step(1, 1, '0, 1, 3'd1, 0);
    step(0, 1, '0, 0, '0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_i_ready",     i_ready,     1);
    check("mid_rst_stage_valid", stage_valid, 0);
    check("mid_rst_hz_en",       hz_en,       5'b11111);
    check("mid_rst_hz_flush_n",  hz_flush_n,  5'b11111);
    check("mid_rst_drain_done",  drain_done,  0);
    @(posedge clk); #1;
    check("mid_rst_hold_done",   drain_done,  0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 1, '0, 0, '0, 0); #2;
    check("post_rst_i_ready", i_ready, 1);
    step(0, 1, '0, 0, '0, 0); #2;
    check("post_rst_accept", stage_valid, 5'b00001);

    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
